flit_ibuf: RTL and testbench
============================

// Module: flit_ibuf
// PURPOSE
//  Per-port input flit FIFO in front of the 2:1 output mux; one instance per mux input (idata_0/1).
//  Absorbs link flits (HEAD/DATA/TAIL) with their VC id and presents them to the mux with valid/ready.
//  Tracks packet framing on the output side so the sel arbiter can hold its grant from HEAD to TAIL.
// PARAMETERS
//  DATAW  66  flit width incl. 2-bit type field in [DATAW-1:DATAW-2] (TYPE_* encodings from define file)
//  VCHW   1   virtual-channel id width
//  DEPTH  4   FIFO entries; power of 2, >=2
// PORTS
//  clk     in   1               rising-edge clock
//  rst_    in   1               asynchronous reset, active low
//  idata   in   DATAW           incoming flit
//  ivalid  in   1               incoming flit valid
//  ivch    in   VCHW            incoming flit VC id
//  iready  out  1               buffer can accept a flit this cycle
//  odata   out  DATAW           head-of-queue flit (to mux idata_N)
//  ovalid  out  1               head-of-queue valid (to mux ivalid_N)
//  ovch    out  VCHW            head-of-queue VC id (to mux ivch_N)
//  oready  in   1               downstream consumes head this cycle (mux selected + link free)
//  olock   out  1               output packet in progress (HEAD popped, TAIL not yet popped)
//  count   out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst_=0, async): wr/rd pointers=0, count=0, FSM=O_IDLE; ovalid=0, odata=0, ovch=0, olock=0, iready=1.
//  - Push: ivalid & iready & type!=TYPE_NONE -> store {idata,ivch} at wr_ptr, wr_ptr++ (mod DEPTH).
//    ivalid=1 with TYPE_NONE: dropped, no state change.
//  - Pop: ovalid & oready -> rd_ptr++ (mod DEPTH). oready with ovalid=0 is ignored.
//  - iready = (count < DEPTH), combinational from count; a simultaneous pop does not free a slot for a
//    push in the same cycle when full.
//  - ovalid = (count != 0); odata/ovch = entry at rd_ptr, forced to 0 when empty.
//  - Latency (no bypass): flit pushed in cycle N is visible on odata in cycle N+1.
//  - Simultaneous push+pop (count 1..DEPTH-1): count unchanged, both pointers advance.
//  - count: +1 push only, -1 pop only; never exceeds DEPTH, never below 0.
//  - Pointers are log2(DEPTH) bits and wrap naturally; full/empty decided by count only.
//  - Output framing FSM (advances on pop only):
//      O_IDLE: pop HEAD -> O_PKT; pop DATA/TAIL -> stay O_IDLE (stray flit, passed through unchanged)
//      O_PKT:  pop TAIL -> O_IDLE; pop DATA -> stay; pop HEAD -> stay O_PKT (new packet, lock kept)
//    olock = (state==O_PKT), registered.
//  - Reset asserted mid-packet: all contents discarded, FSM to O_IDLE, olock deasserts asynchronously.
// CONFIGURATION
//  FLIT_IBUF_BYPASS_EN defined: when count==0, ivalid=1, type!=NONE and oready=1, the flit passes
//    combinationally idata->odata (ovalid=1, ovch=ivch) and is not written; FSM updates as a pop.
//    If oready=0 it is written normally. iready unchanged. Zero-cycle latency when empty.
//  Not defined: no combinational idata->odata path; latency always >=1 cycle.
// TESTING
//  1 Reset: rst_=0 with count=3 -> count=0, ovalid=0, odata=0, olock=0, iready=1 immediately.
//  2 Fill: oready=0, push 5 flits (DEPTH=4) -> iready=0 after 4th, 5th not stored, count=4;
//    then oready=1 -> 4 flits out in push order, ovch matches.
//  3 Packet: HEAD, 20 DATA, TAIL, oready=1 every cycle -> olock=1 from the cycle after HEAD pop
//    through TAIL pop, 0 the cycle after; odata sequence identical, no bubbles after first.
//  4 Stream: ivalid=1, oready=1 for 50 cycles with count=2 -> count stays 2, throughput 1 flit/cycle.
//  5 Wrap: push/pop 3*DEPTH+1 flits, oready toggled 1010.. -> no loss, order kept across pointer wrap.
//  6 Bypass (FLIT_IBUF_BYPASS_EN): empty, push HEAD 0x09 with oready=1 -> odata=HEAD same cycle,
//    count stays 0; without macro -> odata valid next cycle, count=1 then 0.

Source files
------------

// File: rtl/flit_ibuf.sv
// Per-port input flit FIFO feeding one mux input, with HEAD..TAIL framing tracked on the pop side.
// Latency 1 cycle; 0 cycles when empty and FLIT_IBUF_BYPASS_EN is defined (flit goes straight through).
// Backpressure: iready drops when count reaches DEPTH; a pop in the same cycle does not reopen it.
module flit_ibuf #(
  parameter int DATAW = 66,
  parameter int VCHW  = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [DATAW-1:0]       idata,
  input  logic                   ivalid,
  input  logic [VCHW-1:0]        ivch,
  output logic                   iready,
  output logic [DATAW-1:0]       odata,
  output logic                   ovalid,
  output logic [VCHW-1:0]        ovch,
  input  logic                   oready,
  output logic                   olock,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  // Flit type field encodings, carried in idata[DATAW-1:DATAW-2]
  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  typedef enum logic {O_IDLE, O_PKT} ostate_e;

  typedef struct packed {
    logic [VCHW-1:0]  vch;
    logic [DATAW-1:0] dat;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  ostate_e         state_q, state_d;

  logic [1:0]       in_type;
  logic [1:0]       out_type;
  logic             push_req;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             out_evt;
  entry_t           head;
  logic [DATAW-1:0] o_dat;
  logic [VCHW-1:0]  o_vch;

  // Handshake and output selection
  always_comb begin
    in_type  = idata[DATAW-1 -: 2];
    push_req = ivalid && (in_type != TYPE_NONE);
    empty    = (cnt_q == '0);
    iready   = (cnt_q != FULL_CNT);
`ifdef FLIT_IBUF_BYPASS_EN
    bypass   = empty && push_req && oready;
`else
    bypass   = 1'b0;
`endif
    push     = push_req && iready && !bypass;
    pop      = !empty && oready;
    head     = mem_q[rd_ptr_q];
    o_dat    = '0;
    o_vch    = '0;
    if (bypass) begin
      o_dat = idata;
      o_vch = ivch;
    end else if (!empty) begin
      o_dat = head.dat;
      o_vch = head.vch;
    end
    out_evt  = pop || bypass;
    out_type = o_dat[DATAW-1 -: 2];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{vch: ivch, dat: idata};
      wr_ptr_d        = wr_ptr_q + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Framing only moves when a flit actually leaves; a HEAD inside a packet keeps the lock
  always_comb begin
    state_d = state_q;
    if (out_evt) begin
      case (state_q)
        O_IDLE:  if (out_type == TYPE_HEAD) state_d = O_PKT;
        O_PKT:   if (out_type == TYPE_TAIL) state_d = O_IDLE;
        default: state_d = O_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= O_IDLE;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  assign odata  = o_dat;
  assign ovch   = o_vch;
  assign ovalid = !empty || bypass;
  assign olock  = (state_q == O_PKT);
  assign count  = cnt_q;

endmodule

// File: tb/tb_flit_ibuf.sv
// Directed bench for flit_ibuf: per-cycle vector table plus packet, stream, wrap, reset and latency sequences.
module tb_flit_ibuf;

  localparam int TN = 0;
  localparam int TH = 1;
  localparam int TD = 2;
  localparam int TT = 3;
`ifdef FLIT_IBUF_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [65:0] idata = '0;
  logic        ivalid = 1'b0;
  logic [0:0]  ivch = '0;
  logic        iready;
  logic [65:0] odata;
  logic        ovalid;
  logic [0:0]  ovch;
  logic        oready = 1'b0;
  logic        olock;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  flit_ibuf #(.DATAW(66), .VCHW(1), .DEPTH(4)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .oready(oready), .olock(olock), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst; int iv; int ity; int ipay; int ivc; int ord;
    int e_ird; int e_ov; int e_ty; int e_pay; int e_ovc; int e_lock; int e_cnt;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [65:0] fl(input int ty, input int pay);
    return {2'(ty), 48'h0, 16'(pay)};
  endfunction

  function automatic int pty(input int k);
    return (k == 0) ? TH : ((k == 21) ? TT : TD);
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int v, input int ty, input int pay, input int vc, input int ord);
    ivalid = (v != 0);
    idata  = fl(ty, pay);
    ivch   = 1'(vc);
    oready = (ord != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    drv(0, TN, 0, 0, 0);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{0,0,TN,0,0,0,     1,0,TN,0,0,0,0};
    vecs[1]  = '{1,1,TH,'h0A,1,0,  1,0,TN,0,0,0,0};
    vecs[2]  = '{1,1,TD,'h0B,0,0,  1,1,TH,'h0A,1,0,1};
    vecs[3]  = '{1,1,TN,'h55,1,0,  1,1,TH,'h0A,1,0,2};
    vecs[4]  = '{1,1,TD,'h0C,1,0,  1,1,TH,'h0A,1,0,2};
    vecs[5]  = '{1,1,TT,'h0D,0,0,  1,1,TH,'h0A,1,0,3};
    vecs[6]  = '{1,1,TD,'hEE,1,0,  0,1,TH,'h0A,1,0,4};
    vecs[7]  = '{1,0,TN,0,0,1,     0,1,TH,'h0A,1,0,4};
    vecs[8]  = '{1,1,TD,'hEF,0,1,  1,1,TD,'h0B,0,1,3};
    vecs[9]  = '{1,0,TN,0,0,1,     1,1,TD,'h0C,1,1,3};
    vecs[10] = '{1,0,TN,0,0,1,     1,1,TT,'h0D,0,1,2};
    vecs[11] = '{1,0,TN,0,0,1,     1,1,TD,'hEF,0,0,1};
    vecs[12] = '{1,0,TN,0,0,1,     1,0,TN,0,0,0,0};
    vecs[13] = '{1,1,TH,'h21,0,0,  1,0,TN,0,0,0,0};
    vecs[14] = '{1,0,TN,0,0,1,     1,1,TH,'h21,0,0,1};
    vecs[15] = '{1,1,TH,'h22,1,0,  1,0,TN,0,0,1,0};
    vecs[16] = '{1,0,TN,0,0,1,     1,1,TH,'h22,1,1,1};
    vecs[17] = '{0,1,TH,'h23,0,0,  1,0,TN,0,0,0,0};
    vecs[18] = '{1,0,TN,0,0,0,     1,0,TN,0,0,0,0};

    // Cycle-by-cycle table: fill to full, NONE drop, overflow drop, drain, framing, reset
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst_ = (vecs[i].rst != 0);
      drv(vecs[i].iv, vecs[i].ity, vecs[i].ipay, vecs[i].ivc, vecs[i].ord);
      #1;
      chk($sformatf("vec%0d iready", i), 80'(iready), 80'(vecs[i].e_ird));
      chk($sformatf("vec%0d ovalid", i), 80'(ovalid), 80'(vecs[i].e_ov));
      chk($sformatf("vec%0d odata", i),  80'(odata),  80'(fl(vecs[i].e_ty, vecs[i].e_pay)));
      chk($sformatf("vec%0d ovch", i),   80'(ovch),   80'(vecs[i].e_ovc));
      chk($sformatf("vec%0d olock", i),  80'(olock),  80'(vecs[i].e_lock));
      chk($sformatf("vec%0d count", i),  80'(count),  80'(vecs[i].e_cnt));
    end

    // Async reset mid-packet with three flits held
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv(1, (i == 0) ? TH : TD, 'h40 + i, 0, 0);
    end
    @(negedge clk);
    drv(0, TN, 0, 0, 1);
    @(negedge clk);
    drv(0, TN, 0, 0, 0);
    #1;
    chk("rst pre count", 80'(count), 80'(3));
    chk("rst pre olock", 80'(olock), 80'(1));
    #2;
    rst_ = 1'b0;
    #1;
    chk("rst count",  80'(count),  80'(0));
    chk("rst ovalid", 80'(ovalid), 80'(0));
    chk("rst odata",  80'(odata),  80'(0));
    chk("rst olock",  80'(olock),  80'(0));
    chk("rst iready", 80'(iready), 80'(1));
    @(negedge clk);
    rst_ = 1'b1;

    // HEAD, 20 DATA, TAIL streamed with oready held high
    do_reset();
    for (int c = 0; c < 24; c++) begin
      int k;
      @(negedge clk);
      if (c < 22) drv(1, pty(c), 'h100 + c, c % 2, 1);
      else drv(0, TN, 0, 0, 1);
      #1;
      k = c - LAT;
      if (k >= 0 && k <= 21) begin
        chk($sformatf("pkt%0d ovalid", c), 80'(ovalid), 80'(1));
        chk($sformatf("pkt%0d odata", c),  80'(odata),  80'(fl(pty(k), 'h100 + k)));
        chk($sformatf("pkt%0d ovch", c),   80'(ovch),   80'(k % 2));
        chk($sformatf("pkt%0d olock", c),  80'(olock),  80'(k >= 1));
      end else begin
        chk($sformatf("pkt%0d ovalid", c), 80'(ovalid), 80'(0));
        chk($sformatf("pkt%0d olock", c),  80'(olock),  80'(0));
      end
    end

    // Steady stream at occupancy 2
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drv(1, TD, 'h200 + i, 0, 0);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      drv(1, TD, 'h202 + c, 0, 1);
      #1;
      chk($sformatf("strm%0d count", c), 80'(count), 80'(2));
      chk($sformatf("strm%0d odata", c), 80'(odata), 80'(fl(TD, 'h200 + c)));
    end

    // Pointer wrap: 13 flits with oready toggling, scoreboard queue
    do_reset();
    begin
      logic [66:0] q[$];
      logic [66:0] exp_f;
      int sent = 0;
      int recv = 0;
      for (int c = 0; c < 200 && recv < 13; c++) begin
        logic byp;
        @(negedge clk);
        if (sent < 13) drv(1, TD, 'h300 + sent, sent % 2, (c % 2 == 0));
        else drv(0, TN, 0, 0, (c % 2 == 0));
        #1;
`ifdef FLIT_IBUF_BYPASS_EN
        byp = (q.size() == 0) && ivalid && oready;
`else
        byp = 1'b0;
`endif
        chk($sformatf("wrap%0d iready", c), 80'(iready), 80'(q.size() < 4));
        chk($sformatf("wrap%0d ovalid", c), 80'(ovalid), 80'((q.size() != 0) || byp));
        if (byp || q.size() != 0) begin
          exp_f = byp ? {ivch, idata} : q[0];
          chk($sformatf("wrap%0d flit", c), 80'({ovch, odata}), 80'(exp_f));
        end
        if (byp) begin
          recv++;
          sent++;
        end else begin
          if (oready && q.size() != 0) begin
            void'(q.pop_front());
            recv++;
          end
          if (ivalid && q.size() < 4 + ((oready && recv > 0) ? 0 : 0) && iready) begin
            q.push_back({ivch, idata});
            sent++;
          end
        end
      end
      chk("wrap received", 80'(recv), 80'(13));
    end

    // Empty-buffer latency, with or without the bypass path
    do_reset();
    @(negedge clk);
    drv(1, TH, 'h09, 1, 1);
    #1;
`ifdef FLIT_IBUF_BYPASS_EN
    chk("lat ovalid0", 80'(ovalid), 80'(1));
    chk("lat odata0",  80'(odata),  80'(fl(TH, 'h09)));
    chk("lat ovch0",   80'(ovch),   80'(1));
`else
    chk("lat ovalid0", 80'(ovalid), 80'(0));
`endif
    @(negedge clk);
    drv(0, TN, 0, 0, 1);
    #1;
`ifdef FLIT_IBUF_BYPASS_EN
    chk("lat count1",  80'(count),  80'(0));
    chk("lat ovalid1", 80'(ovalid), 80'(0));
`else
    chk("lat count1",  80'(count),  80'(1));
    chk("lat ovalid1", 80'(ovalid), 80'(1));
    chk("lat odata1",  80'(odata),  80'(fl(TH, 'h09)));
`endif
    @(negedge clk);
    #1;
    chk("lat count2", 80'(count), 80'(0));
    chk("lat olock2", 80'(olock), 80'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
